// File: rtl/exa_crosb_demux.sv
// Packet-level crossbar demultiplexer: latches a route on the first beat and forwards beats through
// one registered stage. The optional sticky error flag is enabled by EXA_CROSB_DEMUX_ERR_EN.
module exa_crosb_demux #(
    parameter int unsigned data_width = 128,
    parameter int unsigned output_num = 16,
    parameter int unsigned sel_width  = $clog2(output_num)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] DATA_i,
    input  logic                  VALID_i,
    input  logic                  LAST_i,
    input  logic                  PRIO_i,
    input  logic [sel_width-1:0]  DEST_i,
    output logic                  READY_o,
    output logic [data_width-1:0] DATA_o,
    output logic                  LAST_o,
    output logic                  PRIO_o,
    output logic [output_num-1:0] VALID_o,
    input  logic [output_num-1:0] READY_i
`ifdef EXA_CROSB_DEMUX_ERR_EN
    ,
    output logic                  ERR_o
`endif
);

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e                  state_q;
    logic                    vld_q;
    logic [sel_width-1:0]    dest_q;
    logic [data_width-1:0]   data_q;
    logic                    last_q;
    logic                    prio_q;

    logic [output_num-1:0]   dest_oh;
    logic                    dest_ready;
    logic                    dest_in_range;
    logic                    accept;
    logic                    drain;
    logic                    load;
    logic                    latch_dest;

    always_comb begin
        dest_oh = '0;
        for (int k = 0; k < int'(output_num); k++) begin
            dest_oh[k] = (dest_q == sel_width'(k));
        end
    end

    assign dest_ready    = |(READY_i & dest_oh);
    assign dest_in_range = (32'(DEST_i) < output_num);

    // In DROP nothing is loaded, so upstream is never throttled by the output stage.
    assign READY_o = (state_q == StDrop) ? 1'b1 : (~vld_q | dest_ready);

    assign accept     = VALID_i & READY_o;
    assign drain      = vld_q & dest_ready;
    assign latch_dest = accept & (state_q == StIdle) & dest_in_range;
    assign load       = latch_dest | (accept & (state_q == StFwd));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            vld_q   <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            // A load in the same cycle as a drain replaces the beat with no bubble.
            if (load) begin
                vld_q  <= 1'b1;
                data_q <= DATA_i;
                last_q <= LAST_i;
                prio_q <= PRIO_i;
            end else if (drain) begin
                vld_q <= 1'b0;
            end

            if (latch_dest) begin
                dest_q <= DEST_i;
            end

            if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        if (!LAST_i) begin
                            state_q <= dest_in_range ? StFwd : StDrop;
                        end
                    end
                    StFwd, StDrop: begin
                        if (LAST_i) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign VALID_o = dest_oh & {output_num{vld_q}};
    assign DATA_o  = data_q;
    assign LAST_o  = last_q;
    assign PRIO_o  = prio_q;

`ifdef EXA_CROSB_DEMUX_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = accept & (((state_q == StIdle) & ~dest_in_range) |
                               ((state_q == StFwd) & (DEST_i != dest_q)));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign ERR_o = err_q;
`endif

endmodule

// File: tb/tb_exa_crosb_demux.sv
// Directed, table-driven bench for exa_crosb_demux with a 12-output instance so that
// out-of-range destinations can be exercised.
module tb_exa_crosb_demux;

    localparam int unsigned DW = 128;
    localparam int unsigned ON = 12;
    localparam int unsigned SW = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          prio_i;
    logic [SW-1:0] dest_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          prio_o;
    logic [ON-1:0] valid_o;
    logic [ON-1:0] ready_i;
`ifdef EXA_CROSB_DEMUX_ERR_EN
    logic          err_o;
`endif

    int n_checks;
    int n_fail;

    exa_crosb_demux #(
        .data_width(DW),
        .output_num(ON),
        .sel_width (SW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .DATA_i (data_i),
        .VALID_i(valid_i),
        .LAST_i (last_i),
        .PRIO_i (prio_i),
        .DEST_i (dest_i),
        .READY_o(ready_o),
        .DATA_o (data_o),
        .LAST_o (last_o),
        .PRIO_o (prio_o),
        .VALID_o(valid_o),
        .READY_i(ready_i)
`ifdef EXA_CROSB_DEMUX_ERR_EN
        ,
        .ERR_o  (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vi;
        logic          li;
        logic          pi;
        logic [SW-1:0] dest;
        logic [7:0]    data;
        logic [ON-1:0] rdy;
        logic          e_rdy;
        logic [ON-1:0] e_vo;
        logic [7:0]    e_data;
        logic          e_last;
        logic          e_prio;
        logic          e_err;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vi, input logic li, input logic pi, input logic [SW-1:0] d,
                         input logic [7:0] dat, input logic [ON-1:0] r);
        valid_i = vi;
        last_i  = li;
        prio_i  = pi;
        dest_i  = d;
        data_i  = {120'd0, dat};
        ready_i = r;
    endtask

    function automatic vec_t mk(input logic vi, input logic li, input logic pi,
                                input logic [SW-1:0] d, input logic [7:0] dat,
                                input logic [ON-1:0] r, input logic er, input logic [ON-1:0] evo,
                                input logic [7:0] ed, input logic el, input logic ep,
                                input logic ee);
        vec_t v;
        v.vi = vi; v.li = li; v.pi = pi; v.dest = d; v.data = dat; v.rdy = r;
        v.e_rdy = er; v.e_vo = evo; v.e_data = ed; v.e_last = el; v.e_prio = ep; v.e_err = ee;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //              vi li pi dest data    rdy       | rdy vo       data    last prio err
        vecs[0]  = mk(1, 0, 0, 4'd5,  8'hA1, 12'hFFF,   1, 12'h020, 8'hA1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 4'd5,  8'hA2, 12'hFFF,   1, 12'h020, 8'hA2, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 4'd5,  8'hA3, 12'hFFF,   1, 12'h020, 8'hA3, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 4'd0,  8'h00, 12'hFFF,   1, 12'h000, 8'hA3, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 4'd5,  8'hB1, 12'hFFF,   1, 12'h020, 8'hB1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 4'd5,  8'hB2, 12'hFDF,   0, 12'h020, 8'hB1, 0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 4'd5,  8'hB2, 12'hFDF,   0, 12'h020, 8'hB1, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 4'd5,  8'hB2, 12'hFDF,   0, 12'h020, 8'hB1, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 4'd5,  8'hB2, 12'hFDF,   0, 12'h020, 8'hB1, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 4'd5,  8'hB2, 12'hFFF,   1, 12'h020, 8'hB2, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 4'd5,  8'hB3, 12'hFFF,   1, 12'h020, 8'hB3, 1, 0, 0);
        vecs[11] = mk(1, 0, 1, 4'd7,  8'hC1, 12'hFFF,   1, 12'h080, 8'hC1, 0, 1, 0);
        vecs[12] = mk(1, 0, 1, 4'd2,  8'hC2, 12'hFFF,   1, 12'h080, 8'hC2, 0, 1, 1);
        vecs[13] = mk(1, 1, 1, 4'd2,  8'hC3, 12'hFFF,   1, 12'h080, 8'hC3, 1, 1, 1);
        vecs[14] = mk(0, 0, 0, 4'd0,  8'h00, 12'hFFF,   1, 12'h000, 8'hC3, 1, 1, 1);
        vecs[15] = mk(1, 0, 0, 4'd14, 8'hD1, 12'hFFF,   1, 12'h000, 8'hC3, 1, 1, 1);
        vecs[16] = mk(1, 1, 0, 4'd3,  8'hD2, 12'hFFF,   1, 12'h000, 8'hC3, 1, 1, 1);
        vecs[17] = mk(1, 1, 0, 4'd3,  8'hE1, 12'hFFF,   1, 12'h008, 8'hE1, 1, 0, 1);
        vecs[18] = mk(0, 0, 0, 4'd0,  8'h00, 12'hFFF,   1, 12'h000, 8'hE1, 1, 0, 1);
        vecs[19] = mk(1, 1, 0, 4'd1,  8'hF1, 12'hFFD,   1, 12'h002, 8'hF1, 1, 0, 1);
        vecs[20] = mk(1, 1, 0, 4'd4,  8'h61, 12'hFFD,   0, 12'h002, 8'hF1, 1, 0, 1);
        vecs[21] = mk(1, 1, 0, 4'd4,  8'h61, 12'hFFD,   0, 12'h002, 8'hF1, 1, 0, 1);
        vecs[22] = mk(1, 1, 0, 4'd4,  8'h61, 12'hFFF,   1, 12'h010, 8'h61, 1, 0, 1);
        vecs[23] = mk(0, 0, 0, 4'd0,  8'h00, 12'hFFF,   1, 12'h000, 8'h61, 1, 0, 1);

        reset = 1'b1;
        drive(0, 0, 0, 4'd0, 8'h00, 12'hFFF);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", DW'(valid_o), '0);
        check("reset_data", data_o, '0);
        check("reset_last", DW'(last_o), '0);
        check("reset_prio", DW'(prio_o), '0);
        check("reset_ready", DW'(ready_o), DW'(1));
`ifdef EXA_CROSB_DEMUX_ERR_EN
        check("reset_err", DW'(err_o), '0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].vi, vecs[i].li, vecs[i].pi, vecs[i].dest, vecs[i].data, vecs[i].rdy);
            #4;
            check($sformatf("v%0d_ready", i), DW'(ready_o), DW'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), DW'(valid_o), DW'(vecs[i].e_vo));
            check($sformatf("v%0d_data", i), data_o, DW'(vecs[i].e_data));
            check($sformatf("v%0d_last", i), DW'(last_o), DW'(vecs[i].e_last));
            check($sformatf("v%0d_prio", i), DW'(prio_o), DW'(vecs[i].e_prio));
`ifdef EXA_CROSB_DEMUX_ERR_EN
            check($sformatf("v%0d_err", i), DW'(err_o), DW'(vecs[i].e_err));
`endif
        end

        // Reset on beat 2 of a packet to 9; the following beat must route by its own DEST_i.
        drive(1, 0, 0, 4'd9, 8'h81, 12'hFFF);
        @(posedge clk);
        #1;
        check("rst_pkt_b1_valid", DW'(valid_o), DW'(12'h200));
        check("rst_pkt_b1_data", data_o, DW'(8'h81));
        reset = 1'b1;
        drive(1, 0, 0, 4'd9, 8'h82, 12'hFFF);
        @(posedge clk);
        #1;
        check("rst_pkt_valid", DW'(valid_o), '0);
        check("rst_pkt_data", data_o, '0);
        check("rst_pkt_last", DW'(last_o), '0);
        check("rst_pkt_ready", DW'(ready_o), DW'(1));
`ifdef EXA_CROSB_DEMUX_ERR_EN
        check("rst_pkt_err", DW'(err_o), '0);
`endif
        reset = 1'b0;
        drive(1, 1, 0, 4'd6, 8'h91, 12'hFFF);
        #4;
        check("post_rst_ready", DW'(ready_o), DW'(1));
        @(posedge clk);
        #1;
        check("post_rst_valid", DW'(valid_o), DW'(12'h040));
        check("post_rst_data", data_o, DW'(8'h91));
        check("post_rst_last", DW'(last_o), DW'(1));
        drive(0, 0, 0, 4'd0, 8'h00, 12'hFFF);
        @(posedge clk);
        #1;
        check("post_rst_drained", DW'(valid_o), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
